// File: rtl/unary_pkg.sv
// Shared types for the unary adder family: host FSM states and phase encoding.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/unary_add_host_if.sv
// Operand and result valid/ready handshakes between a binary datapath and the unary host.
interface unary_add_host_if #(
  parameter int unsigned W = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_err
  );

endinterface

// File: rtl/unary_ser.sv
// Binary-to-unary serializer: after load, emits val consecutive registered pulses while run is high.
module unary_ser #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         run,
  output logic         pulse,
  output logic         last_c
);

  logic [W-1:0] tgt_q;
  logic [W-1:0] cnt_q;
  logic         pulse_q;

  // cnt_q counts pulses already placed on the line, including the one now showing
  assign last_c = (cnt_q >= tgt_q);
  assign pulse  = pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (load) begin
      tgt_q   <= val;
      cnt_q   <= W'(val != '0);
      pulse_q <= (val != '0);
    end else if (run && !last_c) begin
      cnt_q   <= cnt_q + W'(1);
      pulse_q <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
    end
  end

endmodule

// File: rtl/unary_add_host.sv
// Drives one unary adder: serializes two binary operands, then decodes the dout pulse train to a sum.
module unary_add_host
  import unary_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned MAXP = 2**W - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  unary_add_host_if.slave bus,
  output logic            A,
  output logic            B,
  output logic            en,
  output logic            read_or_write,
  input  logic            dout,
  input  logic            C
);

  localparam int unsigned  CW      = W + 1;
  localparam logic [W-1:0] SUM_MAX = W'(MAXP);

  state_e        state_q, state_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          en_q, en_d;
  logic          rw_q, rw_d;
  logic          accept_c;
  logic          run_c;
  logic          last_a_c;
  logic          last_b_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign run_c    = (state_q == READ);

  unary_ser #(.W(W)) u_ser_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_c),
    .val    (bus.in_a),
    .run    (run_c),
    .pulse  (A),
    .last_c (last_a_c)
  );

  unary_ser #(.W(W)) u_ser_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_c),
    .val    (bus.in_b),
    .run    (run_c),
    .pulse  (B),
    .last_c (last_b_c)
  );

  // Next-state and next-output logic; cyc_d counts cycles spent in the current state
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    cyc_d   = '0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          sum_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = (bus.in_a == '0 && bus.in_b == '0) ? WRITE : READ;
        end
      end
      READ: begin
        cyc_d = cyc_q + CW'(1);
        // C during the first READ cycle reflects the idle adder, not this operation
        if (cyc_q != '0) carry_d = carry_q | C;
        if (last_a_c && last_b_c) begin
          state_d = WRITE;
          cyc_d   = '0;
        end
      end
      WRITE: begin
        cyc_d = cyc_q + CW'(1);
        // First WRITE cycle: dout is still the read-phase zero, C is from the last READ edge
        if (cyc_q == '0) begin
          carry_d = carry_q | C;
        end else if (dout) begin
          if (sum_q == SUM_MAX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            sum_d = sum_q + W'(1);
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    en_d        = (state_d == READ) || (state_d == WRITE);
    rw_d        = (state_d == WRITE) ? RW_WRITE : RW_READ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= RW_READ;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign bus.out_err   = err_q;
  assign en            = en_q;
  assign read_or_write = rw_q;

endmodule

// File: tb/tb_unary_add_host.sv
// Bench for unary_add_host: behavioural unary adder stub, directed and random operand checks.
module tb_unary_add_host;

  logic clk;
  logic rst_n;
  logic A, B, en, read_or_write;
  logic dout, C;
  logic stuck;

  int n_checks = 0;
  int n_fail   = 0;
  int a_hi     = 0;
  int b_hi     = 0;
  int d_hi     = 0;
  int acc      = 0;

  unary_add_host_if #(.W(4)) bus ();

  unary_add_host #(.W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .A             (A),
    .B             (B),
    .en            (en),
    .read_or_write (read_or_write),
    .dout          (dout),
    .C             (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unary adder: 4-bit count, registered dout/C; stuck forces dout high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  = 0;
      dout <= 1'b0;
      C    <= 1'b0;
    end else begin
      C    <= 1'b0;
      dout <= stuck;
      if (en && !read_or_write) begin
        acc = acc + int'(A) + int'(B);
        if (acc >= 16) begin
          acc = acc - 16;
          C   <= 1'b1;
        end
      end else if (en && read_or_write && acc > 0) begin
        dout <= 1'b1;
        acc  = acc - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (A) a_hi++;
    if (B) b_hi++;
    if (read_or_write && dout) d_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_A"},         32'(A), 0);
    check({tag, "_B"},         32'(B), 0);
    check({tag, "_en"},        32'(en), 0);
    check({tag, "_rw"},        32'(read_or_write), 0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_sum"},   32'(bus.out_sum), 0);
    check({tag, "_out_carry"}, 32'(bus.out_carry), 0);
    check({tag, "_out_err"},   32'(bus.out_err), 0);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    stuck         = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction; expected results come from operand arithmetic only
  task automatic run_op(input int a, input int b, input int hold, input bit stuck_mode);
    int mx, lat, a0, b0, d0;
    int exp_sum, exp_carry, exp_err, exp_lat, exp_ones;
    mx        = (a > b) ? a : b;
    exp_carry = ((a + b) >= 16) ? 1 : 0;
    if (stuck_mode) begin
      exp_sum  = 15;
      exp_err  = 1;
      exp_lat  = mx + 18;
      exp_ones = 17;
    end else begin
      exp_sum  = (a + b) % 16;
      exp_err  = 0;
      exp_lat  = mx + exp_sum + 3;
      exp_ones = exp_sum;
    end
    stuck = stuck_mode;

    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 1);
    a0 = a_hi;
    b0 = b_hi;
    d0 = d_hi;
    bus.in_a      = 4'(a);
    bus.in_b      = 4'(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_busy", 32'(bus.in_ready), 0);

    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("latency",   32'(lat), exp_lat);
    check("out_sum",   32'(bus.out_sum), exp_sum);
    check("out_carry", 32'(bus.out_carry), exp_carry);
    check("out_err",   32'(bus.out_err), exp_err);
    check("done_en",   32'(en), 0);
    check("a_pulses",  32'(a_hi - a0), a);
    check("b_pulses",  32'(b_hi - b0), b);
    check("dout_ones", 32'(d_hi - d0), exp_ones);

    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'($urandom);
      bus.in_b     = 4'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_sum",   32'(bus.out_sum), exp_sum);
      check("hold_carry", 32'(bus.out_carry), exp_carry);
      check("hold_ready", 32'(bus.in_ready), 0);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 0);
    check("release_ready", 32'(bus.in_ready), 1);
    check("release_en",    32'(en), 0);
    stuck = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    stuck         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_op(3, 4, 0, 1'b0);
    run_op(9, 9, 0, 1'b0);
    run_op(15, 1, 0, 1'b0);
    run_op(0, 0, 0, 1'b0);
    run_op(3, 4, 5, 1'b0);
    run_op(2, 3, 0, 1'b1);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset in the middle of READ
    @(negedge clk);
    bus.in_a     = 4'd6;
    bus.in_b     = 4'd2;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_read_A",  32'(A), 1);
    check("mid_read_en", 32'(en), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
